// File: rtl/branch_update_sequencer.sv
// Branch update sequencer for a global branch predictor.
// Keeps in-flight conditional branches in program order. Each resolve
// sends exactly one registered update (index, actual direction) to the
// predictor. A mispredict flushes all younger entries and raises a
// one-cycle recovery pulse, during which the queue takes no new work.
module branch_update_sequencer #(
  parameter int k     = 4,  // predictor index / global history width
  parameter int DEPTH = 8   // in-flight entries, power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // fetch side: one allocation per predicted branch
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [k-1:0]               alloc_index,
  input  logic                       alloc_pred,
  // execute side: oldest-first resolution
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  // predictor update port
  output logic                       upd_valid,
  output logic [k-1:0]               upd_index,
  output logic                       upd_result,
  // recovery and status
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       resolve_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  // RUN accepts traffic; FLUSH is the single recovery cycle after a mispredict.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // One queued branch: the history index it was predicted with and its guess.
  typedef struct packed {
    logic [k-1:0] index;
    logic         pred;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_entry;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_nxt;
  logic [AW-1:0] tail_nxt;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_nxt;

  state_t        state;
  state_t        state_nxt;

  logic          alloc_fire;
  logic          resolve_fire;
  logic          resolve_miss;
  logic          err_set;

  // Next-state, handshake and pointer arithmetic for the current cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    state_nxt    = state;
    head_entry   = mem[head];
    alloc_ready  = 1'b0;
    alloc_fire   = 1'b0;
    resolve_fire = 1'b0;
    resolve_miss = 1'b0;
    err_set      = 1'b0;
    head_nxt     = head;
    tail_nxt     = tail;
    occ_nxt      = occ;

    // Deliberately independent of resolve_valid: a full queue never takes
    // an allocation in the same cycle as a resolve frees a slot.
    alloc_ready  = rst_n && (state == RUN) && (occ < OW'(DEPTH));
    alloc_fire   = alloc_valid && alloc_ready;

    // Resolves only count in RUN; during FLUSH they are silently dropped.
    resolve_fire = resolve_valid && (state == RUN) && (occ != '0);
    err_set      = resolve_valid && (state == RUN) && (occ == '0);
    resolve_miss = resolve_fire && (head_entry.pred != resolve_taken);

    if (resolve_fire) head_nxt = head + AW'(1);
    if (alloc_fire)   tail_nxt = tail + AW'(1);
    occ_nxt = occ + OW'(alloc_fire) - OW'(resolve_fire);

    // A mispredict discards everything younger, including a branch
    // allocated at the very same edge: collapse the queue onto the tail.
    if (resolve_miss) begin
      head_nxt = tail_nxt;
      occ_nxt  = '0;
    end

    unique case (state)
      RUN:     if (resolve_miss) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Queue pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      occ  <= occ_nxt;
    end
  end

  // Entry storage, written at the tail on an accepted allocation.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is not reset; occupancy and the pointers
    // decide which slots are live, so stale contents are never read.
    if (alloc_fire) mem[tail] <= '{index: alloc_index, pred: alloc_pred};
  end

  // Registered predictor update, recovery pulse and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_result  <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      upd_valid  <= resolve_fire;
      mispredict <= resolve_miss;
      // Index and result hold their last values between updates.
      if (resolve_fire) begin
        upd_index  <= head_entry.index;
        upd_result <= resolve_taken;
      end
      if (err_set) resolve_err <= 1'b1;
    end
  end

  assign occupancy = occ;

endmodule

// File: tb/tb_branch_update_sequencer.sv
// Self-checking bench for branch_update_sequencer: directed scenarios
// followed by random traffic, compared against a queue-based model.
module tb_branch_update_sequencer;

  localparam int K     = 4;
  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           alloc_valid = 1'b0;
  logic           alloc_ready;
  logic [K-1:0]   alloc_index = '0;
  logic           alloc_pred = 1'b0;
  logic           resolve_valid = 1'b0;
  logic           resolve_taken = 1'b0;
  logic           upd_valid;
  logic [K-1:0]   upd_index;
  logic           upd_result;
  logic           mispredict;
  logic [OW-1:0]  occupancy;
  logic           resolve_err;

  branch_update_sequencer #(.k(K), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_index   (alloc_index),
    .alloc_pred    (alloc_pred),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_result    (upd_result),
    .mispredict    (mispredict),
    .occupancy     (occupancy),
    .resolve_err   (resolve_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order list of in-flight branches plus the
  // externally visible status it implies.
  typedef struct {
    logic [K-1:0] idx;
    logic         pred;
  } ent_t;

  ent_t         q[$];
  bit           m_flush;
  bit           m_err;
  bit           m_uv;
  bit           m_mis;
  logic [K-1:0] m_idx;
  logic         m_res;

  task automatic model_reset();
    q.delete();
    m_flush = 0;
    m_err   = 0;
    m_uv    = 0;
    m_mis   = 0;
    m_idx   = '0;
    m_res   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".upd_valid"},   32'(upd_valid),   32'(m_uv));
    check({tag, ".mispredict"},  32'(mispredict),  32'(m_mis));
    check({tag, ".upd_index"},   32'(upd_index),   32'(m_idx));
    check({tag, ".upd_result"},  32'(upd_result),  32'(m_res));
    check({tag, ".occupancy"},   32'(occupancy),   32'(q.size()));
    check({tag, ".resolve_err"}, 32'(resolve_err), 32'(m_err));
  endtask

  // One clock cycle: drive inputs, check the combinational handshake,
  // advance the model by the rules, then check the registered outputs.
  task automatic cycle(input string tag, input logic av, input logic [K-1:0] ai,
                       input logic ap, input logic rv, input logic rt);
    bit   ready;
    bit   acc_alloc;
    bit   acc_res;
    ent_t h;
    alloc_valid   = av;
    alloc_index   = ai;
    alloc_pred    = ap;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
    ready = !m_flush && (q.size() < DEPTH);
    check({tag, ".alloc_ready"}, 32'(alloc_ready), 32'(ready));
    acc_alloc = av && ready;
    acc_res   = rv && !m_flush && (q.size() > 0);
    if (rv && !m_flush && q.size() == 0) m_err = 1;
    m_uv  = 0;
    m_mis = 0;
    if (acc_res) begin
      h     = q.pop_front();
      m_uv  = 1;
      m_idx = h.idx;
      m_res = rt;
      m_mis = (h.pred != rt);
    end
    if (acc_alloc) q.push_back('{idx: ai, pred: ap});
    if (m_mis) q.delete();
    m_flush = m_mis;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alloc(input string tag, input logic [K-1:0] ai, input logic ap);
    cycle(tag, 1'b1, ai, ap, 1'b0, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic rt);
    cycle(tag, 1'b0, '0, 1'b0, 1'b1, rt);
  endtask

  task automatic do_reset();
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    check("reset.alloc_ready", 32'(alloc_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: three correct predictions resolved back to back.
    alloc("t1.a0", 4'd3, 1'b1);
    alloc("t1.a1", 4'd5, 1'b0);
    alloc("t1.a2", 4'd9, 1'b1);
    resolve("t1.r0", 1'b1);
    resolve("t1.r1", 1'b0);
    resolve("t1.r2", 1'b1);
    idle("t1.idle");

    // 2: fill to DEPTH, refuse a ninth, free one slot.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc("t2.fill", K'(i + 1), 1'(i & 1));
    check("t2.full_occupancy", 32'(occupancy), 32'(DEPTH));
    alloc("t2.ninth", 4'hF, 1'b1);
    resolve("t2.r", q[0].pred);
    idle("t2.after");

    // 3: mispredict flushes younger entries; FLUSH cycle ignores traffic.
    do_reset();
    alloc("t3.a0", 4'd2, 1'b1);
    alloc("t3.a1", 4'd4, 1'b0);
    alloc("t3.a2", 4'd6, 1'b1);
    resolve("t3.miss", 1'b0);
    check("t3.upd_index", 32'(upd_index), 32'd2);
    check("t3.mispredict", 32'(mispredict), 32'd1);
    cycle("t3.flush", 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
    idle("t3.run");

    // 4: simultaneous alloc and resolve with a single entry in flight.
    do_reset();
    alloc("t4.a", 4'd7, 1'b0);
    cycle("t4.both", 1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
    check("t4.upd_index_old", 32'(upd_index), 32'd7);
    resolve("t4.r", 1'b1);
    check("t4.upd_index_new", 32'(upd_index), 32'd8);

    // 5: resolve on empty queue sets a sticky error.
    do_reset();
    resolve("t5.empty", 1'b1);
    check("t5.err_set", 32'(resolve_err), 32'd1);
    alloc("t5.a", 4'd1, 1'b1);
    resolve("t5.r", 1'b1);
    idle("t5.idle");
    do_reset();
    check("t5.err_cleared", 32'(resolve_err), 32'd0);

    // 6: asynchronous reset with entries queued and an update pulse live.
    do_reset();
    for (int i = 0; i < 6; i++) alloc("t6.fill", K'(i + 10), 1'b0);
    resolve("t6.r", 1'b0);
    check("t6.pulse_live", 32'(upd_valid), 32'd1);
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t6.async");
    check("t6.alloc_ready_in_reset", 32'(alloc_ready), 32'd0);
    @(posedge clk);
    #1;
    check_outputs("t6.held");
    resolve_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle("t6.release");
    check("t6.ready_after", 32'(alloc_ready), 32'd1);

    // Random traffic, mostly correct predictions with occasional misses.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic av;
      logic rv;
      logic rt;
      av = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 5);
      if (q.size() > 0) rt = ($urandom_range(0, 9) == 0) ? ~q[0].pred : q[0].pred;
      else              rt = 1'($urandom);
      cycle("rand", av, K'($urandom), 1'($urandom), rv, rt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_update_sequencer.md
Name: branch_update_sequencer

Overview:
- Sequences training of the global branch predictor by tracking in-flight conditional branches in program order.
- Fetch allocates one entry per predicted branch, carrying the history index used and the predicted direction. Execute resolves branches oldest-first.
- The block issues exactly one registered update per resolved branch to the predictor's update/result/up_index inputs.
- On a mispredict, the block flushes all younger in-flight entries and signals recovery to fetch.

Parameters:
- k, 4, predictor index / global history width in bits.
- DEPTH, 8, in-flight branch entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alloc_valid  input  1  fetch presents a predicted branch.
- alloc_ready  output  1  queue can accept an allocation this cycle.
- alloc_index  input  k  predictor index (history) used for the prediction.
- alloc_pred  input  1  predicted direction (1 = taken).
- resolve_valid  input  1  execute resolves the oldest in-flight branch.
- resolve_taken  input  1  actual direction.
- upd_valid  output  1  one-cycle pulse; drives predictor update.
- upd_index  output  k  drives predictor up_index.
- upd_result  output  1  drives predictor result.
- mispredict  output  1  one-cycle pulse; resolved direction differed from prediction.
- occupancy  output  clog2(DEPTH)+1  current entry count.
- resolve_err  output  1  sticky: resolve_valid seen while queue empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Queue emptied, head/tail pointers = 0, state = RUN.
  - upd_valid, upd_index, upd_result, mispredict, resolve_err, occupancy all = 0.
  - alloc_ready = 0 while rst_n is low.
  - Reset asserted mid-operation discards all entries and any pending pulse immediately.
- Storage: circular FIFO of {index[k], pred}. Pointers wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- alloc_ready is combinational: 1 when state == RUN and occupancy < DEPTH. Because it does not depend on resolve_valid, a full queue does not accept an allocation in the same cycle as a resolve.
- Allocation is accepted on a rising edge with alloc_valid && alloc_ready; the entry is written at the tail and the tail advances.
- Resolve is accepted on a rising edge with resolve_valid and occupancy > 0; it pops the head entry.
- Resolve latency is 1 cycle: outputs are registered. For a resolve accepted at edge N, in the following cycle:
  - upd_valid = 1;
  - upd_index = head index;
  - upd_result = resolve_taken;
  - mispredict = (head pred != resolve_taken).
  - upd_valid and mispredict are high for exactly one cycle. upd_index and upd_result hold their last values when upd_valid is 0.
- resolve_valid with occupancy == 0 is ignored: no pop and no update. resolve_err is set and stays set until reset.
- Simultaneous alloc and non-mispredicting resolve: both take effect; occupancy is unchanged. With occupancy == 1, the resolved entry is the old head, not the new one.
- State machine RUN / FLUSH:
  - RUN -> FLUSH on a mispredicting resolve. At that edge every remaining entry is discarded, including an allocation accepted at the same edge: occupancy = 0 and head = tail.
  - FLUSH lasts exactly one cycle, coinciding with the mispredict pulse. alloc_ready = 0 and resolve_valid is ignored without setting resolve_err. The state then returns to RUN.
  - A correct prediction stays in RUN.
- Back-to-back resolves on consecutive cycles yield consecutive upd_valid pulses. This is legal only while no mispredict occurs.
- The predictor's own history shift is driven by upd_valid/upd_result, so history is updated in resolve order only.

Test Plan:
1. Reset, then allocate idx 3/pred 1, idx 5/pred 0, idx 9/pred 1. Resolve taken, not-taken, taken on consecutive cycles -> three upd_valid pulses with (3,1), (5,0), (9,1); mispredict never asserted; occupancy 3 -> 0.
2. Fill with DEPTH=8 entries -> alloc_ready = 0 and occupancy = 8; a 9th alloc_valid is not accepted. One resolve -> alloc_ready returns to 1 the cycle after.
3. Allocate idx 2/pred 1, idx 4/pred 0, idx 6/pred 1. Resolve not-taken -> next cycle upd_valid = 1, upd_index = 2, upd_result = 0, mispredict = 1, occupancy = 0, alloc_ready = 0 for that one cycle, then 1.
4. occupancy = 1 (idx 7/pred 0). Same cycle: alloc idx 8/pred 1 and resolve not-taken -> update (7,0); occupancy stays 1. A later resolve yields upd_index = 8.
5. Resolve on empty queue -> no upd_valid; resolve_err = 1 and it holds through further traffic until rst_n is pulsed low.
6. Assert rst_n low asynchronously with 5 entries queued and a resolve in flight -> outputs go to 0 immediately with no update pulse. After release, alloc_ready = 1 and occupancy = 0.
